// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: operation codes, stack delta encodings, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stack_pkg;

    // Request operation codes carried on req_op; codes 7 and above are NOP.
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_POPREP  = 3'd4,
        OP_POPN    = 3'd5,
        OP_CLEAR   = 3'd6
    } op_e;

    // Stack pointer movement encodings on stk_delta.
    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_POP  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack controller: turns push/pop/replace/popn/clear requests into registered stack strobes and tracks occupancy.
// Latency: strobes appear the cycle after acceptance; POPN/CLEAR issue one pop per cycle for n cycles.
// Backpressure: req_ready drops while a multi-pop drain is in progress (busy).
//
// Ports: clk/resetq (async active-low); req_valid/req_ready/req_op/req_data/req_cnt request channel;
// stk_we/stk_delta/stk_wd drive the downstream stack; depth/empty/full/busy status;
// err_clr clears the sticky err_ovf/err_unf flags.
// Build option: define STACK_CTRL_GUARD_EN to refuse overflowing/underflowing ops and flag them;
// without it every op is issued, depth saturates at 0 and CAP, and the error flags read 0.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 18,
    localparam int CAP   = DEPTH + 1,
    localparam int CW    = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [CW-1:0]    req_cnt,
    output logic             stk_we,
    output logic [1:0]       stk_delta,
    output logic [WIDTH-1:0] stk_wd,
    output logic [CW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             busy,
    input  logic             err_clr,
    output logic             err_ovf,
    output logic             err_unf
);

`ifdef STACK_CTRL_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] TWO   = CW'(2);
    localparam logic [CW-1:0] CAP_V = CW'(CAP);

    state_e           state, state_nxt;
    logic [CW-1:0]    drain_cnt, cnt_nxt;
    logic [CW-1:0]    depth_nxt;
    logic [CW-1:0]    drain_n;
    logic             we_nxt;
    logic [1:0]       delta_nxt;
    logic [WIDTH-1:0] wd_nxt;
    logic             ovf_set, unf_set;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state == ST_DRAIN);
    assign empty     = (depth == '0);
    assign full      = (depth == CAP_V);

    // Pop count for a multi-pop request. With the guard on, POPN never
    // drains past the bottom; CLEAR always drains exactly what is held.
    always_comb begin
        drain_n = req_cnt;
        if (op_e'(req_op) == OP_CLEAR) begin
            drain_n = depth;
        end else if (GUARD_EN && (req_cnt > depth)) begin
            drain_n = depth;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = drain_cnt;
        depth_nxt = depth;
        we_nxt    = 1'b0;
        delta_nxt = DELTA_HOLD;
        wd_nxt    = '0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_PUSH: begin
                            if (GUARD_EN && full) begin
                                ovf_set = 1'b1;
                            end else begin
                                we_nxt    = 1'b1;
                                delta_nxt = DELTA_PUSH;
                                wd_nxt    = req_data;
                                if (!full) depth_nxt = depth + ONE;
                            end
                        end
                        OP_POP: begin
                            if (GUARD_EN && empty) begin
                                unf_set = 1'b1;
                            end else begin
                                delta_nxt = DELTA_POP;
                                if (!empty) depth_nxt = depth - ONE;
                            end
                        end
                        OP_REPLACE: begin
                            if (GUARD_EN && empty) begin
                                unf_set = 1'b1;
                            end else begin
                                we_nxt = 1'b1;
                                wd_nxt = req_data;
                            end
                        end
                        OP_POPREP: begin
                            // Overwrites the cell below the top, so two cells must be held.
                            if (GUARD_EN && (depth < TWO)) begin
                                unf_set = 1'b1;
                            end else begin
                                we_nxt    = 1'b1;
                                delta_nxt = DELTA_POP;
                                wd_nxt    = req_data;
                                if (!empty) depth_nxt = depth - ONE;
                            end
                        end
                        OP_POPN, OP_CLEAR: begin
                            // A zero count falls through as a NOP.
                            if (drain_n != '0) begin
                                state_nxt = ST_DRAIN;
                                cnt_nxt   = drain_n;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_DRAIN: begin
                delta_nxt = DELTA_POP;
                if (!empty) depth_nxt = depth - ONE;
                cnt_nxt = drain_cnt - ONE;
                if (drain_cnt == ONE) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            depth     <= '0;
            stk_we    <= 1'b0;
            stk_delta <= DELTA_HOLD;
            stk_wd    <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= cnt_nxt;
            depth     <= depth_nxt;
            stk_we    <= we_nxt;
            stk_delta <= delta_nxt;
            stk_wd    <= wd_nxt;
        end
    end

`ifdef STACK_CTRL_GUARD_EN
    // Sticky flags; a new error on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (ovf_set)      err_ovf <= 1'b1;
            else if (err_clr) err_ovf <= 1'b0;
            if (unf_set)      err_unf <= 1'b1;
            else if (err_clr) err_unf <= 1'b0;
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
    logic unused_err;
    assign unused_err = ^{err_clr, ovf_set, unf_set};
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: reference model of occupancy and error flags, scoreboard of expected stack strobes.
// Latency: expected strobes are queued at request time and matched whenever the DUT drives a stack action.
// Backpressure: requests are only driven while req_ready is high; drains are waited out with a cycle bound.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 18;
    localparam int CAP   = DEPTH + 1;
    localparam int CW    = $clog2(CAP + 1);
`ifdef STACK_CTRL_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetq = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = 3'd0;
    logic [WIDTH-1:0] req_data = '0;
    logic [CW-1:0]    req_cnt = '0;
    logic             stk_we;
    logic [1:0]       stk_delta;
    logic [WIDTH-1:0] stk_wd;
    logic [CW-1:0]    depth;
    logic             empty, full, busy;
    logic             err_clr = 1'b0;
    logic             err_ovf, err_unf;

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_cnt(req_cnt),
        .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd),
        .depth(depth), .empty(empty), .full(full), .busy(busy),
        .err_clr(err_clr), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int  md   = 0;
    bit  movf = 1'b0;
    bit  munf = 1'b0;
    logic [WIDTH+2:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every cycle the DUT drives a stack action, it must be the oldest expected one.
    always @(negedge clk) begin
        logic [WIDTH+2:0] exp_act;
        if (resetq && (stk_we || (stk_delta != 2'b00))) begin
            if (sb.size() == 0) begin
                chk("spurious_act", 64'({stk_we, stk_delta, stk_wd}), 64'd0);
            end else begin
                exp_act = sb.pop_front();
                chk("stk_act", 64'({stk_we, stk_delta, stk_wd}), 64'(exp_act));
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, ":depth"}, 64'(depth), 64'(md));
        chk({tag, ":empty"}, 64'(empty), 64'(md == 0));
        chk({tag, ":full"},  64'(full),  64'(md == CAP));
        chk({tag, ":ovf"},   64'(err_ovf), 64'(movf));
        chk({tag, ":unf"},   64'(err_unf), 64'(munf));
    endtask

    // Called just after a falling edge with the DUT idle; returns after a falling edge
    // once the operation (including any drain) has completed.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] data,
                         input int cnt, input bit clr);
        int n;
        int b;
        int rb;
        bit oset;
        bit uset;
        n = 0; b = 0; rb = 0; oset = 1'b0; uset = 1'b0;
        chk({tag, ":ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_data = data; req_cnt = CW'(cnt); err_clr = clr;
        case (op)
            OP_PUSH:
                if (GUARD && md == CAP) oset = 1'b1;
                else begin
                    sb.push_back({1'b1, 2'b01, data});
                    if (md < CAP) md++;
                end
            OP_POP:
                if (GUARD && md == 0) uset = 1'b1;
                else begin
                    sb.push_back({1'b0, 2'b11, {WIDTH{1'b0}}});
                    if (md > 0) md--;
                end
            OP_REPLACE:
                if (GUARD && md < 1) uset = 1'b1;
                else sb.push_back({1'b1, 2'b00, data});
            OP_POPREP:
                if (GUARD && md < 2) uset = 1'b1;
                else begin
                    sb.push_back({1'b1, 2'b11, data});
                    if (md > 0) md--;
                end
            OP_POPN: begin
                n = cnt;
                if (GUARD && n > md) n = md;
            end
            OP_CLEAR: n = md;
            default: ;
        endcase
        for (int i = 0; i < n; i++) sb.push_back({1'b0, 2'b11, {WIDTH{1'b0}}});
        if (GUARD) begin
            if (oset) movf = 1'b1; else if (clr) movf = 1'b0;
            if (uset) munf = 1'b1; else if (clr) munf = 1'b0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0; err_clr = 1'b0; req_data = '0; req_cnt = '0;
        @(negedge clk);
        if (n > 0) begin
            while (busy && b < 64) begin
                b++;
                if (req_ready) rb++;
                @(negedge clk);
            end
            chk({tag, ":drain_len"}, 64'(b), 64'(n));
            chk({tag, ":ready_in_drain"}, 64'(rb), 64'd0);
            md = (n > md) ? 0 : md - n;
        end else begin
            chk({tag, ":busy"}, 64'(busy), 64'd0);
        end
        check_state(tag);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        movf = 1'b0; munf = 1'b0;
        @(negedge clk);
        check_state("clr");
    endtask

    task automatic fill_to(input int target);
        while (md < target) do_op("fill", OP_PUSH, WIDTH'($urandom), 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        #12;
        chk("rst:depth", 64'(depth), 64'd0);
        chk("rst:empty", 64'(empty), 64'd1);
        chk("rst:full",  64'(full),  64'd0);
        chk("rst:busy",  64'(busy),  64'd0);
        chk("rst:act",   64'({stk_we, stk_delta, stk_wd}), 64'd0);
        chk("rst:err",   64'({err_ovf, err_unf}), 64'd0);
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        chk("rst:ready_first", 64'(req_ready), 64'd1);

        // Single push, strobes for one cycle then back to idle.
        do_op("push1234", OP_PUSH, 16'h1234, 0, 1'b0);
        @(negedge clk);
        chk("push1234:we_off", 64'(stk_we), 64'd0);
        chk("push1234:delta_off", 64'(stk_delta), 64'd0);

        // Fill to capacity, then one more push.
        fill_to(CAP);
        chk("full:flag", 64'(full), 64'd1);
        do_op("push_at_full", OP_PUSH, 16'hDEAD, 0, 1'b0);
        pulse_clr();

        // Clear the full stack.
        do_op("clear_full", OP_CLEAR, '0, 0, 1'b0);

        // depth 5, POPN 3.
        fill_to(5);
        do_op("popn3", OP_POPN, '0, 3, 1'b0);
        chk("popn3:depth2", 64'(depth), 64'd2);

        // depth 2, POPREP, then REPLACE at depth 1.
        do_op("poprep", OP_POPREP, 16'hBEEF, 0, 1'b0);
        do_op("replace", OP_REPLACE, 16'hAAAA, 0, 1'b0);
        do_op("pop_last", OP_POP, '0, 0, 1'b0);

        // Underflow cases on an empty / shallow stack.
        do_op("pop_empty", OP_POP, '0, 0, 1'b0);
        do_op("pop_empty_clr", OP_POP, '0, 0, 1'b1);
        pulse_clr();
        do_op("replace_empty", OP_REPLACE, 16'h5555, 0, 1'b0);
        fill_to(1);
        do_op("poprep_shallow", OP_POPREP, 16'h7777, 0, 1'b0);
        pulse_clr();

        // Zero-count POPN, oversize POPN, unused opcode.
        do_op("popn0", OP_POPN, '0, 0, 1'b0);
        fill_to(3);
        do_op("popn_over", OP_POPN, '0, 7, 1'b0);
        do_op("opcode7", 3'd7, 16'hFFFF, 5, 1'b0);

        // Reset arriving mid-CLEAR after two pops.
        fill_to(4);
        chk("midrst:ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = OP_CLEAR; req_cnt = '0;
        sb.push_back({1'b0, 2'b11, {WIDTH{1'b0}}});
        sb.push_back({1'b0, 2'b11, {WIDTH{1'b0}}});
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 resetq = 1'b0;
        #1;
        md = 0; movf = 1'b0; munf = 1'b0;
        chk("midrst:depth", 64'(depth), 64'd0);
        chk("midrst:delta", 64'(stk_delta), 64'd0);
        chk("midrst:busy", 64'(busy), 64'd0);
        chk("midrst:sb", 64'(sb.size()), 64'd0);
        @(negedge clk);
        resetq = 1'b1;
        repeat (4) @(negedge clk);
        check_state("midrst_after");
        chk("midrst:idle", 64'(busy), 64'd0);

        // Random mix of operations against the model.
        for (int k = 0; k < 60; k++) begin
            do_op("rand", 3'($urandom_range(0, 7)), WIDTH'($urandom),
                  int'($urandom_range(0, CAP + 1)), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        chk("sb_left", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the stack cell width in bits.
REQ-002 SHALL have parameter DEPTH, default 18, the tail depth of the downstream stack; total capacity is CAP = DEPTH+1 cells.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock.
REQ-004 resetq input 1: asynchronous active-low reset.
REQ-005 req_valid input 1: the stack-operation request is valid.
REQ-006 req_ready output 1: the block accepts a request this cycle.
REQ-007 req_op input 3: operation code; values are defined in stack_pkg.
REQ-008 req_data input WIDTH: value for push and replace operations.
REQ-009 req_cnt input CW=$clog2(CAP+1): pop count for POPN.
REQ-010 stk_we output 1: drives the stack write enable.
REQ-011 stk_delta output 2: drives the stack delta; 00 = hold, 01 = push, 11 = pop.
REQ-012 stk_wd output WIDTH: drives the stack write data.
REQ-013 depth output CW: current occupancy, 0..CAP.
REQ-014 empty and full outputs 1: empty = (depth == 0); full = (depth == CAP).
REQ-015 busy output 1: the FSM is in DRAIN.
REQ-016 err_clr input 1: clears the sticky error flags.
REQ-017 err_ovf and err_unf outputs 1: sticky overflow and underflow flags.

Function
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready; req_ready = (state == IDLE).
REQ-019 stk_we, stk_delta and stk_wd SHALL be registered: for a request accepted at edge N, they are driven during cycle N+1 and return to 0/00 after it unless another operation is issued.
REQ-020 depth SHALL update at the acceptance edge for single-cycle ops, and at each issue edge during DRAIN.
REQ-021 NOP: no stack action.
REQ-022 PUSH: we=1, delta=01, wd=req_data; depth+1.
REQ-023 POP: we=0, delta=11; depth-1.
REQ-024 REPLACE: we=1, delta=00, wd=req_data; depth unchanged; requires depth ≥ 1.
REQ-025 POPREP: we=1, delta=11, wd=req_data; depth-1; requires depth ≥ 2.
REQ-026 POPN: the effective count is n = min(req_cnt, depth) with the guard enabled, or n = req_cnt without it.
REQ-027 POPN with n == 0 SHALL complete as a NOP.
REQ-028 POPN with n > 0 SHALL enter DRAIN and issue exactly n consecutive pops, one per cycle.
REQ-029 CLEAR SHALL behave as POPN with n = depth.
REQ-030 FSM: IDLE → DRAIN on accepted POPN/CLEAR with n > 0; DRAIN → IDLE on the edge issuing the last pop; no other states.
REQ-031 Unused op codes SHALL act as NOP.
REQ-032 Simultaneous err_clr and a new error event: the set SHALL win.

Reset
REQ-033 On resetq low: state = IDLE, depth = 0, stk_we = 0, stk_delta = 00, stk_wd = 0, err_ovf = 0, err_unf = 0, and any pending drain count is discarded.
REQ-034 Reset asserted mid-DRAIN SHALL abort the drain immediately; stack contents are logically discarded (the stack itself has no reset).
REQ-035 After resetq deasserts, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-036 With macro STACK_CTRL_GUARD_EN defined, a PUSH at full, or a POP/REPLACE/POPREP with insufficient depth, SHALL issue no stack action, leave depth unchanged, and set err_ovf or err_unf respectively.
REQ-037 With STACK_CTRL_GUARD_EN undefined: all ops are issued unconditionally; depth saturates at 0 and CAP; err_ovf and err_unf are tied 0.

Structure
REQ-038 Package stack_pkg SHALL hold: op codes (NOP=0, PUSH=1, POP=2, REPLACE=3, POPREP=4, POPN=5, CLEAR=6), delta constants DELTA_HOLD/PUSH/POP, and the FSM state typedef.
REQ-039 The block SHALL be a single module; no sub-module.

Verification
REQ-040 Reset then PUSH 0x1234 → cycle after accept: stk_we=1, stk_delta=01, stk_wd=0x1234; depth=1; the next cycle stk_we=0, stk_delta=00.
REQ-041 19 PUSHes then a 20th PUSH (guard on) → depth=19, full=1, the 20th issues no action, err_ovf=1; err_clr pulse → err_ovf=0.
REQ-042 depth=5, POPN req_cnt=3 → busy=1, req_ready=0 for 3 cycles, exactly 3 cycles with stk_delta=11, then depth=2 and IDLE.
REQ-043 depth=4, CLEAR; assert resetq low after 2 pops → depth=0, stk_delta=00, IDLE, no further pops.
REQ-044 Empty stack, POP (guard on) → no action, err_unf=1; POP issued together with err_clr → err_unf stays 1.
REQ-045 depth=2, POPREP 0xBEEF → stk_we=1, stk_delta=11, stk_wd=0xBEEF; depth=1.
